tact_player: RTL and testbench

//   Sequencer stage directly upstream of the PWM sound generator. Walks the tact ROM, prefetches words

---
 rtl/tact_player.sv | 169 ++++++++++++++++
 tb/tb_tact_player.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tact_player.sv
// tact_player: walks the tact ROM, prefetches words into a small FIFO and plays each tone period.
// Define TACT_PLAYER_LOOP_EN to replay the song endlessly instead of stopping at the end marker.
module tact_player #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int TICK_DIV   = 100000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aud_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] tone_data,
    output logic              tone_valid,
    output logic              done,
    output logic              underrun
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_END} state_t;

    state_t            state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              end_seen;
    logic [15:0]       dur_cnt;
    logic [TICK_W-1:0] tick_cnt;

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] load_word;
    logic [1:0]        pop_n;
    logic              fifo_empty, fifo_full, push, rom_marker, head_marker;
    logic              tick_last, tone_end, want_word;
    logic              load, to_end, to_load, starve;
`ifdef TACT_PLAYER_LOOP_EN
    logic [DATA_W-1:0] head_next;
    logic              head_next_marker;
`endif

    // NOTE: every signal gets a default before any branch, so no latch can be inferred here.
    always_comb begin
        head        = fifo_mem[rd_ptr];
        fifo_empty  = (count == '0);
        fifo_full   = (count == CNT_W'(FIFO_DEPTH));
        push        = aud_en && !fifo_full && !end_seen;
        rom_marker  = (rom_data[31:16] == 16'h0);
        head_marker = (head[31:16] == 16'h0);
        tick_last   = (tick_cnt == TICK_W'(TICK_DIV - 1));
        tone_end    = (state == S_PLAY) && (dur_cnt == 16'd1) && tick_last;
        want_word   = (state == S_LOAD) || tone_end;
`ifdef TACT_PLAYER_LOOP_EN
        head_next        = fifo_mem[rd_ptr + PTR_W'(1)];
        head_next_marker = (head_next[31:16] == 16'h0);
`endif
        pop_n     = 2'd0;
        load      = 1'b0;
        to_end    = 1'b0;
        to_load   = 1'b0;
        starve    = 1'b0;
        load_word = head;
        if (want_word) begin
            if (fifo_empty) begin
                starve = tone_end;
            end else if (!head_marker) begin
                pop_n = 2'd1;
                load  = 1'b1;
            end else begin
`ifdef TACT_PLAYER_LOOP_EN
                // Skip the marker and start the first word again without a gap when it is queued.
                if (count >= CNT_W'(2) && !head_next_marker) begin
                    pop_n     = 2'd2;
                    load      = 1'b1;
                    load_word = head_next;
                end else begin
                    pop_n   = 2'd1;
                    to_load = 1'b1;
                end
`else
                pop_n  = 2'd1;
                to_end = 1'b1;
`endif
            end
        end
    end

    // NOTE: storage is not reset; occupancy lives in the pointers and count, so stale words are never read.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rom_data;
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            end_seen   <= 1'b0;
            dur_cnt    <= '0;
            tick_cnt   <= '0;
            tone_data  <= '0;
            tone_valid <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else if (!aud_en) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            end_seen   <= 1'b0;
            dur_cnt    <= '0;
            tick_cnt   <= '0;
            tone_data  <= '0;
            tone_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
`ifdef TACT_PLAYER_LOOP_EN
                rom_addr <= rom_marker ? '0 : rom_addr + ADDR_W'(1);
`else
                rom_addr <= rom_addr + ADDR_W'(1);
                end_seen <= rom_marker;
`endif
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            count  <= count + CNT_W'(push) - CNT_W'(pop_n);

            case (state)
                S_IDLE: if (!fifo_empty) state <= S_LOAD;
                S_LOAD, S_PLAY: begin
                    if (load) begin
                        state      <= S_PLAY;
                        dur_cnt    <= load_word[31:16];
                        tick_cnt   <= '0;
                        tone_data  <= {{(DATA_W-16){1'b0}}, load_word[15:0]};
                        tone_valid <= |load_word[15:0];
                    end else if (to_end) begin
                        state      <= S_END;
                        tone_data  <= '0;
                        tone_valid <= 1'b0;
                        done       <= 1'b1;
                    end else if (starve || to_load) begin
                        state      <= S_LOAD;
                        tone_data  <= '0;
                        tone_valid <= 1'b0;
                        if (starve) underrun <= 1'b1;
                    end else if (state == S_PLAY) begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            dur_cnt  <= dur_cnt - 16'd1;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                S_END:   done  <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tact_player.sv
// Self-checking bench for tact_player: directed scenarios plus random songs against a tone-timeline model.
module tb_tact_player;
    localparam int TICK_A = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        aud_en;
    logic        aud_en_w;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] tone_data;
    logic        tone_valid, done, underrun;
    logic [1:0]  rom_addr_w;
    logic [31:0] rom_data_w;
    logic [31:0] tone_data_w;
    logic        tone_valid_w, done_w, underrun_w;

    logic [31:0] rom_a [16];
    logic [31:0] rom_w [4];
    int          wexp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data   = rom_a[rom_addr];
    assign rom_data_w = rom_w[rom_addr_w];

    tact_player #(.ADDR_W(4), .DATA_W(32), .TICK_DIV(TICK_A), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .aud_en(aud_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .tone_data(tone_data), .tone_valid(tone_valid), .done(done), .underrun(underrun)
    );

    tact_player #(.ADDR_W(2), .DATA_W(32), .TICK_DIV(1), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .rst(rst), .aud_en(aud_en_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .tone_data(tone_data_w), .tone_valid(tone_valid_w), .done(done_w), .underrun(underrun_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise aud_en from a negedge and follow the expected tone timeline; stop early after sample 'cut'.
    task automatic run_song(input int cut);
        int exp_q[$];
        int len;
        int reps;
        len = 0;
        while (len < 15 && rom_a[len][31:16] != 16'h0) len++;
`ifdef TACT_PLAYER_LOOP_EN
        reps = 2;
`else
        reps = 1;
`endif
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < len; i++)
                repeat (int'(rom_a[i][31:16]) * TICK_A) exp_q.push_back(int'(rom_a[i][15:0]));

        aud_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("latency_valid", 32'(tone_valid), 0);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check("tone_data", tone_data, exp_q[k]);
            check("tone_valid", 32'(tone_valid), 32'(exp_q[k] != 0));
            check("done_low", 32'(done), 0);
            check("underrun_low", 32'(underrun), 0);
            if (k == cut) return;
        end
`ifndef TACT_PLAYER_LOOP_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("end_done", 32'(done), 1);
            check("end_tone", tone_data, 0);
            check("end_valid", 32'(tone_valid), 0);
        end
        check("end_addr", 32'(rom_addr), 32'(len + 1));
`endif
    endtask

    task automatic stop_play();
        aud_en = 1'b0;
        @(negedge clk);
        check("stop_valid", 32'(tone_valid), 0);
        check("stop_tone", tone_data, 0);
        check("stop_addr", 32'(rom_addr), 0);
        check("stop_done", 32'(done), 0);
    endtask

    task automatic make_song(input int len);
        for (int i = 0; i < 16; i++) rom_a[i] = {16'($urandom_range(1, 3)), 16'($urandom)};
        for (int i = 0; i < len; i++)
            if ($urandom_range(0, 3) == 0) rom_a[i][15:0] = 16'h0;
        rom_a[len] = {16'h0, 16'($urandom)};
    endtask

    initial begin
        rst      = 1'b1;
        aud_en   = 1'b0;
        aud_en_w = 1'b0;
        for (int i = 0; i < 16; i++) rom_a[i] = 32'h0;
        rom_w = '{32'h0001_0011, 32'h0001_0022, 32'h0001_0033, 32'h0001_0044};
        repeat (2) @(negedge clk);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_tone", tone_data, 0);
        check("rst_valid", 32'(tone_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_w_addr", 32'(rom_addr_w), 0);
        check("rst_w_valid", 32'(tone_valid_w), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed song: 0x100 for 3 ticks, rest for 2 ticks, end marker.
        rom_a[0] = 32'h0003_0100;
        rom_a[1] = 32'h0002_0000;
        rom_a[2] = 32'h0000_0000;
        run_song(-1);
        stop_play();

        // Drop aud_en in the 5th playing cycle, then restart from word 0.
        run_song(4);
        stop_play();
        run_song(-1);
        stop_play();

`ifndef TACT_PLAYER_LOOP_EN
        // Marker-only song: done after the third edge, never any tone.
        rom_a[0] = 32'h0000_0000;
        aud_en = 1'b1;
        @(negedge clk);
        check("mk_done_n0", 32'(done), 0);
        @(negedge clk);
        check("mk_done_n1", 32'(done), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mk_done", 32'(done), 1);
            check("mk_valid", 32'(tone_valid), 0);
        end
        stop_play();
`endif

        // Random songs: plain runs, enable drops and asynchronous reset pulses mid-play.
        for (int s = 0; s < 9; s++) begin
            make_song($urandom_range(1, 6));
            case (s % 3)
                0: begin
                    run_song(-1);
                    stop_play();
                end
                1: begin
                    run_song($urandom_range(0, 5));
                    stop_play();
                    run_song(-1);
                    stop_play();
                end
                default: begin
                    run_song($urandom_range(0, 5));
                    #2 rst = 1'b1;
                    #1;
                    check("arst_addr", 32'(rom_addr), 0);
                    check("arst_tone", tone_data, 0);
                    check("arst_valid", 32'(tone_valid), 0);
                    check("arst_done", 32'(done), 0);
                    check("arst_underrun", 32'(underrun), 0);
                    #1 rst = 1'b0;
                    run_song(-1);
                    stop_play();
                end
            endcase
        end

        // One-tick tones with no marker: back-to-back periods and address wrap.
        aud_en_w = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("w_latency_valid", 32'(tone_valid_w), 0);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("w_tone", tone_data_w, wexp[k % 4]);
            check("w_valid", 32'(tone_valid_w), 1);
            check("w_underrun", 32'(underrun_w), 0);
            check("w_done", 32'(done_w), 0);
            check("w_addr", 32'(rom_addr_w), 32'((k + 3) % 4));
        end
        aud_en_w = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
